serial_paralelo: RTL and testbench
==================================

# serial_paralelo

Receive-side deserializer that pairs with `paralelo_serial`. It takes the 1-bit line stream clocked at `clk_32f` and finds byte alignment by hunting for the 0xBC comma. After four consecutive aligned commas it declares the link active, then delivers every non-comma byte as an 8-bit word with a valid flag. It sits directly downstream of `paralelo_serial`, so the TX→RX loop can be closed in `Banco_pruebas`.

## Interface
Parameters:
- `COMMA`, 8'hBC: idle/alignment symbol.
- `LOCK_COUNT`, 4: consecutive aligned commas required to reach LOCKED (range 2..15).

Ports:
- `clk_32f`  input  1  single clock, one serial bit per rising edge.
- `reset`  input  1  asynchronous, active-high reset; one clock, reset asynchronous active-high.
- `data_in`  input  1  serial bit, MSB of each byte first.
- `data_out`  output  8  last received non-comma byte.
- `valid_out`  output  1  high while `data_out` holds a byte from the most recent byte slot.
- `active`  output  1  high in LOCKED.

## Operation
- Shift register: `sr <= {sr[6:0], data_in}` on every edge. Define `nxt = {sr[6:0], data_in}`.
- Bit counter `bit_cnt` (3 bits, wraps 7→0): counts bits since the byte boundary.
- Byte event: an edge where `bit_cnt == 7` in LOCKING or LOCKED. The byte under test is `nxt`.
- Comma counter `bc_cnt` (4 bits).
- State machine, encoded as 2 bits:
  - UNLOCKED: compare `nxt` to COMMA on every edge. On a match: `bit_cnt<=0`, `bc_cnt<=1`, go to LOCKING. Otherwise `bit_cnt` is don't-care and is held at 0.
  - LOCKING: `bit_cnt` increments each edge. On a byte event with `nxt==COMMA`: `bc_cnt++`. If `bc_cnt+1 == LOCK_COUNT`, go to LOCKED and set `active<=1`. On a byte event with `nxt!=COMMA`: go to UNLOCKED with `bc_cnt<=0`. The comma search restarts on the next edge; that same edge is not re-checked.
  - LOCKED: `bit_cnt` free-runs. On a byte event with `nxt!=COMMA`: `data_out<=nxt`, `valid_out<=1`. On a byte event with `nxt==COMMA`: `valid_out<=0`, `data_out` holds. Between byte events all outputs hold. LOCKED is left only through `reset`; there is no loss-of-lock detection.
- Outside LOCKED: `valid_out=0`, `data_out=8'h00`, `active=0`.
- Reset (asserted at any time, including mid-byte or mid-lock): state UNLOCKED. `sr`, `bit_cnt`, `bc_cnt`, `data_out` = 0. `valid_out`, `active` = 0. All take effect immediately, without waiting for a clock edge.

## Timing
- Alignment edge E: the edge that samples the 8th bit of the first comma.
- Commas k = 2..LOCK_COUNT are evaluated at edges E+8(k−1). With default 4, `active` rises after edge E+24.
- Data latency: `data_out`/`valid_out` update at the edge that samples the byte's LSB, so they are visible one cycle after that bit is on `data_in`. They then hold for 8 cycles until the next byte event.
- First data byte: LSB sampled at edge E+32 (default); `valid_out` rises after that edge.
- A comma pattern straddling a byte boundary in LOCKED is ignored; alignment never re-slips once locked.
- Release of `reset` between edges: the first sampled bit is the one present at the first rising edge after release.

## Test plan
- Reset values: hold `reset` high with random `data_in`. `data_out=00`, `valid_out=0`, `active=0`. Drop reset and send all zeros for 64 cycles: outputs stay at 0.
- Lock with phase offset: 3 junk bits (101), then BC×4 MSB first. `active` rises exactly 24 cycles after the first comma's LSB edge. `valid_out` stays 0.
- Data after lock: following lock, send 0x55, 0xA3, 0xBC, 0x0F. `data_out` goes 55 (valid) → A3 (valid) → A3 with `valid_out=0` → 0F (valid), each held 8 cycles and updated 1 cycle after the byte's LSB.
- Broken lock: BC, BC, 0x00, then BC×4. At the 0x00 byte event the block returns to UNLOCKED. `active` rises only 24 cycles after the first comma of the second run.
- Reset mid-operation: assert `reset` for 1 cycle in the middle of a data byte while LOCKED. Outputs clear asynchronously. Relocking requires 4 fresh commas.
- Loopback: `paralelo_serial`→`serial_paralelo` in `Banco_pruebas` with bytes 01..10 and idle gaps. The received `valid_out` bytes match the transmitted sequence in order.

Source files
------------

// File: rtl/serial_paralelo.sv
// serial_paralelo: receive-side deserializer for the paralelo_serial line stream.
// It finds byte alignment by hunting for the comma symbol. After LOCK_COUNT
// consecutive aligned commas it enters LOCKED, and from then on it delivers
// every non-comma byte.
//
// Ports:
//   clk_32f    in   1  line clock; one serial bit is sampled on each rising edge
//   reset      in   1  asynchronous, active-high reset
//   data_in    in   1  serial bit, MSB of each byte first
//   data_out   out  8  last received non-comma byte (00 outside LOCKED)
//   valid_out  out  1  data_out holds the byte from the most recent byte slot
//   active     out  1  link is LOCKED
module serial_paralelo #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BC_W   = 4;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   sr_q;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BC_W-1:0]     bc_cnt_q, bc_cnt_d;
  logic [BYTE_W-1:0]   data_out_d;
  logic                valid_out_d;
  logic                active_d;

  // Candidate byte ending with the bit sampled at this edge
  logic [BYTE_W-1:0]   nxt;
  logic                is_comma;
  logic                byte_evt;
  logic [BC_W-1:0]     bc_inc;
  logic                lock_hit;

  assign nxt      = {sr_q[BYTE_W-2:0], data_in};
  assign is_comma = (nxt == COMMA);
  assign byte_evt = (bit_cnt_q == CNT_W'(7));
  assign bc_inc   = BC_W'(bc_cnt_q + BC_W'(1));
  assign lock_hit = (bc_inc == BC_W'(LOCK_COUNT));

  // State and datapath registers
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= ST_UNLOCKED;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= nxt;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_out  <= data_out_d;
      valid_out <= valid_out_d;
      active    <= active_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bc_cnt_d    = bc_cnt_q;
    data_out_d  = data_out;
    valid_out_d = valid_out;
    active_d    = active;

    unique case (state_q)
      ST_UNLOCKED: begin
        // Slide one bit per edge; the bit counter carries no meaning here
        bit_cnt_d   = '0;
        bc_cnt_d    = '0;
        data_out_d  = '0;
        valid_out_d = 1'b0;
        active_d    = 1'b0;
        if (is_comma) begin
          bc_cnt_d = BC_W'(1);
          state_d  = ST_LOCKING;
        end
      end

      ST_LOCKING: begin
        bit_cnt_d   = CNT_W'(bit_cnt_q + CNT_W'(1));
        data_out_d  = '0;
        valid_out_d = 1'b0;
        active_d    = 1'b0;
        if (byte_evt) begin
          if (is_comma) begin
            bc_cnt_d = bc_inc;
            if (lock_hit) begin
              state_d  = ST_LOCKED;
              active_d = 1'b1;
            end
          end else begin
            // Alignment lost: restart the hunt on the following edge
            bc_cnt_d = '0;
            state_d  = ST_UNLOCKED;
          end
        end
      end

      ST_LOCKED: begin
        // Alignment is frozen; only reset leaves this state
        bit_cnt_d = CNT_W'(bit_cnt_q + CNT_W'(1));
        active_d  = 1'b1;
        if (byte_evt) begin
          if (is_comma) begin
            valid_out_d = 1'b0;
          end else begin
            data_out_d  = nxt;
            valid_out_d = 1'b1;
          end
        end
      end

      default: begin
        state_d     = ST_UNLOCKED;
        bit_cnt_d   = '0;
        bc_cnt_d    = '0;
        data_out_d  = '0;
        valid_out_d = 1'b0;
        active_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: self-checking bench for serial_paralelo.
// The bench serializes bytes MSB first. For each byte it pushes the expected
// {data_out, valid_out, active} onto a scoreboard. The entry is popped and
// compared right after the edge that samples the byte's LSB. On the seven
// earlier edges of the byte the outputs must still hold the previous value.
module tb_serial_paralelo;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       act;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks;
  int   n_fail;

  serial_paralelo #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, " data_out"},  32'(data_out),  32'(e.data));
    check({tag, " valid_out"}, 32'(valid_out), 32'(e.valid));
    check({tag, " active"},    32'(active),    32'(e.act));
  endtask

  task automatic check_hold(input string tag);
    check(tag, 32'({data_out, valid_out, active}), 32'(cur));
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] ed,
                           input logic ev, input logic ea);
    exp_t e;
    e = {ed, ev, ea};
    sb.push_back(e);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i != 0) begin
        check_hold($sformatf("hold in byte %02h", b));
      end else begin
        e = sb.pop_front();
        check_outs($sformatf("byte %02h", b), e);
        cur = e;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
    cur = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cur      = '0;
    reset    = 1'b1;
    data_in  = 1'b0;

    // Reset values, with random line data while reset is held
    #1;
    check_outs("reset t0", '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_32f);
      data_in = 1'($urandom);
      @(posedge clk_32f);
      #1;
      check_outs("reset held", '0);
    end
    @(negedge clk_32f);
    reset = 1'b0;
    // 64 zero bits: nothing may change
    for (int i = 0; i < 8; i++) send_byte(8'h00, 8'h00, 1'b0, 1'b0);

    // Lock with a 3-bit phase offset: active rises exactly at the 4th comma
    send_bit(1'b1); check_hold("junk");
    send_bit(1'b0); check_hold("junk");
    send_bit(1'b1); check_hold("junk");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b1);

    // Data after lock; a comma clears valid but keeps the last data
    send_byte(8'h55, 8'h55, 1'b1, 1'b1);
    send_byte(8'hA3, 8'hA3, 1'b1, 1'b1);
    send_byte(8'hBC, 8'hA3, 1'b0, 1'b1);
    send_byte(8'h0F, 8'h0F, 1'b1, 1'b1);

    // A comma pattern straddling 0B|C0 must not re-align the link
    send_byte(8'h0B, 8'h0B, 1'b1, 1'b1);
    send_byte(8'hC0, 8'hC0, 1'b1, 1'b1);
    send_byte(8'h77, 8'h77, 1'b1, 1'b1);

    // Reset for one cycle in the middle of a data byte
    for (int i = 7; i >= 4; i--) begin
      send_bit(i[0]);
      check_hold("hold before mid reset");
    end
    @(negedge clk_32f);
    reset = 1'b1;
    #1;
    check_outs("async reset", '0);
    @(posedge clk_32f);
    #1;
    check_outs("reset edge", '0);
    @(negedge clk_32f);
    reset = 1'b0;
    cur = '0;
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b0);
      check_hold("after mid reset");
    end
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b1);
    send_byte(8'h3C, 8'h3C, 1'b1, 1'b1);

    // Broken lock: BC, BC, 00 drops back; four fresh commas are needed
    do_reset();
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b1);

    // Loopback-style traffic: bytes 01..10 with idle commas every 4 bytes
    begin
      logic [7:0] last;
      last = 8'h00;
      for (int k = 1; k <= 16; k++) begin
        send_byte(8'(k), 8'(k), 1'b1, 1'b1);
        last = 8'(k);
        if (k % 4 == 0) send_byte(8'hBC, last, 1'b0, 1'b1);
      end
    end

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
